// File: rtl/priority_encoder_8to3_pkg.sv
// Shared constants and types for the 8-to-3 priority encoder.
package priority_encoder_8to3_pkg;

    localparam int NUM_IN = 8;
    localparam int IDX_W  = 3;

    typedef logic [NUM_IN-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]  idx_t;

endpackage : priority_encoder_8to3_pkg

// File: rtl/priority_encoder_8to3_comb.sv
// Purely combinational priority encoder: returns the index of the highest
// set bit of an 8-bit request vector, plus a flag telling whether any bit
// was set at all (so "no request" can be told apart from "line 0").
module priority_encoder_8to3_comb
    import priority_encoder_8to3_pkg::*;
(
    input  req_vec_t vec_i,
    output idx_t     idx_o,
    output logic     any_o
);

    // Scan from the lowest line upward so a higher asserted line overrides any lower one.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule : priority_encoder_8to3_comb

// File: rtl/priority_encoder_8to3.sv
// 8-input priority encoder with registered index and valid outputs.
// Line h has the highest priority and line a the lowest; the result
// appears one clock after the inputs are sampled.
module priority_encoder_8to3
    import priority_encoder_8to3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic h,
    input  logic g,
    input  logic f,
    input  logic e,
    input  logic d,
    input  logic c,
    input  logic b,
    input  logic a,
    output idx_t out,
    output logic valid
);

    req_vec_t reqVec;
    idx_t     out_d;
    logic     valid_d;
    idx_t     out_q;
    logic     valid_q;

    assign reqVec = {h, g, f, e, d, c, b, a};

    priority_encoder_8to3_comb u_comb (
        .vec_i (reqVec),
        .idx_o (out_d),
        .any_o (valid_d)
    );

    // Capture the encode result each cycle; reset takes precedence over it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule : priority_encoder_8to3

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench for priority_encoder_8to3: directed reset, sweep,
// one-hot, masking, mid-stream reset and latency steps plus random vectors,
// all compared against an arithmetic reference model.
module tb_priority_encoder_8to3;

    logic       clk;
    logic       rst;
    logic [7:0] vecIn;
    logic [2:0] outObs;
    logic       validObs;

    int total;
    int bad;

    priority_encoder_8to3 dut (
        .clk   (clk),
        .rst   (rst),
        .h     (vecIn[7]),
        .g     (vecIn[6]),
        .f     (vecIn[5]),
        .e     (vecIn[4]),
        .d     (vecIn[3]),
        .c     (vecIn[2]),
        .b     (vecIn[1]),
        .a     (vecIn[0]),
        .out   (outObs),
        .valid (validObs)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference index: floor(log2(v)) for nonzero v, zero otherwise.
    function automatic int refIndex(input int v);
        int idx;
        idx = 0;
        while (v > 1) begin
            v   = v / 2;
            idx = idx + 1;
        end
        return idx;
    endfunction

    task automatic checkOutput(input string tag, input logic [2:0] expOut, input logic expValid);
        total++;
        assert (outObs === expOut)
        else begin
            bad++;
            $error("[TB] FAIL %s out: observed=%0d expected=%0d", tag, outObs, expOut);
        end
        total++;
        assert (validObs === expValid)
        else begin
            bad++;
            $error("[TB] FAIL %s valid: observed=%0b expected=%0b", tag, validObs, expValid);
        end
    endtask

    // Drive one vector (and reset level) at the falling edge, then check
    // the registered result just after the following rising edge.
    task automatic applyStimulus(input string tag, input logic [7:0] v, input logic r);
        logic [2:0] expOut;
        logic       expValid;
        @(negedge clk);
        vecIn = v;
        rst   = r;
        @(posedge clk);
        #1;
        if (r) begin
            expOut   = 3'd0;
            expValid = 1'b0;
        end else begin
            expOut   = 3'(refIndex(int'(v)));
            expValid = (v != 8'h00);
        end
        checkOutput(tag, expOut, expValid);
    endtask

    initial begin
        logic [7:0] v;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        vecIn = 8'hFF;

        $display("[TB] reset with all inputs high");
        applyStimulus("reset0", 8'hFF, 1'b1);
        applyStimulus("reset1", 8'hFF, 1'b1);
        applyStimulus("reset_release", 8'hFF, 1'b0);

        $display("[TB] exhaustive sweep with mid-stream reset at 0x55");
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            if (v == 8'h55) begin
                applyStimulus("sweep_midreset", v, 1'b1);
                applyStimulus("sweep_after_reset", v, 1'b0);
            end else begin
                applyStimulus("sweep", v, 1'b0);
            end
        end

        $display("[TB] spot values");
        applyStimulus("spot00", 8'h00, 1'b0);
        checkOutput("spot00_const", 3'd0, 1'b0);
        applyStimulus("spot01", 8'h01, 1'b0);
        checkOutput("spot01_const", 3'd0, 1'b1);
        applyStimulus("spot02", 8'h02, 1'b0);
        checkOutput("spot02_const", 3'd1, 1'b1);
        applyStimulus("spot03", 8'h03, 1'b0);
        checkOutput("spot03_const", 3'd1, 1'b1);
        applyStimulus("spot10", 8'h10, 1'b0);
        checkOutput("spot10_const", 3'd4, 1'b1);
        applyStimulus("spot7F", 8'h7F, 1'b0);
        checkOutput("spot7F_const", 3'd6, 1'b1);
        applyStimulus("spot80", 8'h80, 1'b0);
        checkOutput("spot80_const", 3'd7, 1'b1);
        applyStimulus("spotFF", 8'hFF, 1'b0);
        checkOutput("spotFF_const", 3'd7, 1'b1);

        $display("[TB] one-hot walk");
        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            applyStimulus("onehot", v, 1'b0);
            checkOutput("onehot_step", 3'(i), 1'b1);
        end

        $display("[TB] priority masking with h high");
        for (int i = 128; i < 256; i++) begin
            applyStimulus("mask_h", 8'(i), 1'b0);
            checkOutput("mask_h_seven", 3'd7, 1'b1);
        end

        $display("[TB] latency and stability between edges");
        applyStimulus("lat_04", 8'h04, 1'b0);
        checkOutput("lat_04_const", 3'd2, 1'b1);
        @(negedge clk);
        checkOutput("lat_04_hold", 3'd2, 1'b1);
        applyStimulus("lat_20", 8'h20, 1'b0);
        checkOutput("lat_20_const", 3'd5, 1'b1);
        @(negedge clk);
        checkOutput("lat_20_hold", 3'd5, 1'b1);

        $display("[TB] random vectors with occasional reset");
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom_range(0, 255));
            applyStimulus("random", v, ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_priority_encoder_8to3
